man_coord_gen: RTL and testbench

MAN_COORD_GEN -- requirements
Module: man_coord_gen

---
 rtl/man_pkg.sv | 19 +
 rtl/man_coord_gen.sv | 136 +++++++++++++
 tb/tb_man_coord_gen.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/man_pkg.sv
// -----------------------------------------------------------------------------
// man_pkg
// Shared constants and types for the Mandelbrot coordinate generator.
//   FPW_DEF   : default fixed-point coordinate width
//   CW_DEF    : default resolution counter width
//   state_t   : generator FSM encoding (IDLE / RUN / DONE)
// -----------------------------------------------------------------------------
package man_pkg;

  localparam int FPW_DEF = 54;
  localparam int CW_DEF  = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/man_coord_gen.sv
// -----------------------------------------------------------------------------
// man_coord_gen
// Walks a frame of hres x vres pixels in raster order, issuing one fixed-point
// (x, y) coordinate per valid/ready handshake to the downstream engine.
//
// Ports
//   clk, rst            : clock, asynchronous active-low reset
//   init                : start pulse; latches x0/y0/xs/ys/hres/vres
//   x0, y0, xs, ys      : top-left coordinate and per-pixel step (FPW bits)
//   hres, vres          : frame size in pixels (CW bits)
//   out_vld, out_rdy    : coordinate handshake
//   out_x, out_y        : current pixel coordinate
//   out_hcnt, out_vcnt  : current pixel column / row
//   done                : frame fully issued (held until next init)
//   npixels             : handshakes completed in the current frame
//   timer               : RUN-cycle count from init to done
//
// Build option
//   MAN_COORD_GEN_TIMER_EN : when defined, timer counts cycles spent in RUN;
//                            otherwise timer is constant 0.
// -----------------------------------------------------------------------------
module man_coord_gen
  import man_pkg::*;
#(
  parameter int FPW = FPW_DEF,
  parameter int CW  = CW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           init,
  input  logic [FPW-1:0] x0,
  input  logic [FPW-1:0] y0,
  input  logic [FPW-1:0] xs,
  input  logic [FPW-1:0] ys,
  input  logic [CW-1:0]  hres,
  input  logic [CW-1:0]  vres,
  output logic           out_vld,
  input  logic           out_rdy,
  output logic [FPW-1:0] out_x,
  output logic [FPW-1:0] out_y,
  output logic [CW-1:0]  out_hcnt,
  output logic [CW-1:0]  out_vcnt,
  output logic           done,
  output logic [31:0]    npixels,
  output logic [31:0]    timer
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t state, state_nxt;

  // Parameters latched at init; live inputs are ignored until the next init.
  logic [FPW-1:0] x0_r, xs_r, ys_r;
  logic [CW-1:0]  hres_r, vres_r;

  logic xfer;
  logic last_col;
  logic last_row;
  logic empty_frame;

  assign out_vld     = (state == RUN);
  assign done        = (state == DONE);
  assign xfer        = out_vld && out_rdy;
  assign last_col    = (out_hcnt == hres_r - CNT_ONE);
  assign last_row    = (out_vcnt == vres_r - CNT_ONE);
  assign empty_frame = (hres == '0) || (vres == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // init has priority in every state, so a restart mid-frame drops any
  // coordinate that was being offered in the same cycle.
  always_comb begin
    state_nxt = state;
    if (init) begin
      state_nxt = empty_frame ? DONE : RUN;
    end else begin
      case (state)
        RUN:     if (xfer && last_col && last_row) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  // Raster walk: step x along a row, then rewind x and step y at row end.
  // Additions wrap silently at FPW bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x0_r     <= '0;
      xs_r     <= '0;
      ys_r     <= '0;
      hres_r   <= '0;
      vres_r   <= '0;
      out_x    <= '0;
      out_y    <= '0;
      out_hcnt <= '0;
      out_vcnt <= '0;
      npixels  <= '0;
    end else if (init) begin
      x0_r     <= x0;
      xs_r     <= xs;
      ys_r     <= ys;
      hres_r   <= hres;
      vres_r   <= vres;
      out_x    <= x0;
      out_y    <= y0;
      out_hcnt <= '0;
      out_vcnt <= '0;
      npixels  <= '0;
    end else if (xfer) begin
      npixels <= npixels + 32'd1;
      if (!last_col) begin
        out_hcnt <= out_hcnt + CNT_ONE;
        out_x    <= out_x + xs_r;
      end else if (!last_row) begin
        out_hcnt <= '0;
        out_x    <= x0_r;
        out_vcnt <= out_vcnt + CNT_ONE;
        out_y    <= out_y + ys_r;
      end
    end
  end

`ifdef MAN_COORD_GEN_TIMER_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              timer <= '0;
    else if (init)         timer <= '0;
    else if (state == RUN) timer <= timer + 32'd1;
  end
`else
  assign timer = '0;
`endif

endmodule

// File: tb/tb_man_coord_gen.sv
// -----------------------------------------------------------------------------
// tb_man_coord_gen
// Directed, table-driven bench for man_coord_gen. Each table row describes a
// frame plus hand-computed last coordinate; every issued coordinate is also
// compared against x0 + h*xs / y0 + v*ys. Hand-written sequences cover empty
// frames, restart mid-frame and reset mid-frame.
// -----------------------------------------------------------------------------
module tb_man_coord_gen;
  import man_pkg::*;

  localparam int FPW = 54;
  localparam int CW  = 12;

  logic           clk = 1'b0;
  logic           rst;
  logic           init;
  logic [FPW-1:0] x0, y0, xs, ys;
  logic [CW-1:0]  hres, vres;
  logic           out_vld;
  logic           out_rdy;
  logic [FPW-1:0] out_x, out_y;
  logic [CW-1:0]  out_hcnt, out_vcnt;
  logic           done;
  logic [31:0]    npixels;
  logic [31:0]    timer;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  man_coord_gen #(.FPW(FPW), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .init     (init),
    .x0       (x0),
    .y0       (y0),
    .xs       (xs),
    .ys       (ys),
    .hres     (hres),
    .vres     (vres),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_x    (out_x),
    .out_y    (out_y),
    .out_hcnt (out_hcnt),
    .out_vcnt (out_vcnt),
    .done     (done),
    .npixels  (npixels),
    .timer    (timer)
  );

  typedef struct {
    logic [CW-1:0]  hres;
    logic [CW-1:0]  vres;
    logic [FPW-1:0] x0;
    logic [FPW-1:0] xs;
    logic [FPW-1:0] y0;
    logic [FPW-1:0] ys;
    bit             stall;
    logic [FPW-1:0] last_x;
    logic [FPW-1:0] last_y;
    int             exp_timer;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int tmr(input int n);
`ifdef MAN_COORD_GEN_TIMER_EN
    return n;
`else
    return 0;
`endif
  endfunction

  // Called at a negedge; pulses init for one clock and returns at the next
  // negedge, where the new frame's first coordinate is on the outputs.
  task automatic do_init(input vec_t v);
    x0 = v.x0; xs = v.xs; y0 = v.y0; ys = v.ys;
    hres = v.hres; vres = v.vres;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
  endtask

  task automatic run_frame(input string name, input vec_t v);
    int total, cnt, cyc, h, vv;
    logic [FPW-1:0] hh, vl, ex, ey, lx, ly;
    total = int'(v.hres) * int'(v.vres);
    cnt = 0; cyc = 0; h = 0; vv = 0;
    lx = '0; ly = '0;
    do_init(v);
    // Scramble live inputs: latched parameters must be used from here on.
    x0 = ~v.x0; xs = v.xs + 7; y0 = ~v.y0; ys = v.ys + 3;
    hres = v.hres + 1; vres = v.vres + 2;
    while (cnt < total && cyc < 200) begin
      out_rdy = v.stall ? (cyc % 2 == 0) : 1'b1;
      #1;
      hh = FPW'(h); vl = FPW'(vv);
      ex = v.x0 + hh * v.xs;
      ey = v.y0 + vl * v.ys;
      chk({name, " coord"}, {out_vld, out_x[30:0], out_y[31:0]},
          {1'b1, ex[30:0], ey[31:0]});
      chk({name, " cnt"}, {out_x, out_hcnt}, {ex, CW'(h)});
      chk({name, " vcnt"}, 64'(out_vcnt), 64'(vv));
      if (out_vld && out_rdy) begin
        lx = out_x; ly = out_y;
        cnt++;
        if (h == int'(v.hres) - 1) begin h = 0; vv++; end
        else h++;
      end
      @(negedge clk);
      cyc++;
    end
    out_rdy = 1'b1;
    #1;
    chk({name, " npix_done"}, 64'(cnt), 64'(total));
    chk({name, " last_x"}, 64'(lx), 64'(v.last_x));
    chk({name, " last_y"}, 64'(ly), 64'(v.last_y));
    chk({name, " vld_off"}, 64'(out_vld), 64'd0);
    chk({name, " done"}, 64'(done), 64'd1);
    chk({name, " npixels"}, 64'(npixels), 64'(total));
    chk({name, " timer"}, 64'(timer), 64'(v.exp_timer));
    repeat (3) @(negedge clk);
    #1;
    chk({name, " hold"}, {out_vld, done, npixels, timer[29:0]},
        {1'b0, 1'b1, 32'(total), 30'(v.exp_timer)});
  endtask

  initial begin
    vec_t v;
    rst = 1'b0; init = 1'b0; out_rdy = 1'b0;
    x0 = '0; y0 = '0; xs = '0; ys = '0; hres = '0; vres = '0;

    //            hres  vres x0                xs           y0       ys               stall last_x  last_y  timer
    vecs[0] = '{12'd4, 12'd3, 54'd0,          54'd1,       54'd0,   54'd1,           1'b0, 54'd3,  54'd2,  tmr(12)};
    vecs[1] = '{12'd4, 12'd3, 54'd0,          54'd1,       54'd0,   54'd1,           1'b1, 54'd3,  54'd2,  tmr(23)};
    vecs[2] = '{12'd2, 12'd2, {FPW{1'b1}},    54'd2,       54'd5,   {FPW{1'b1}},     1'b0, 54'd1,  54'd4,  tmr(4)};
    vecs[3] = '{12'd1, 12'd1, 54'd7,          54'd9,       54'd9,   54'd4,           1'b0, 54'd7,  54'd9,  tmr(1)};
    vecs[4] = '{12'd3, 12'd2, 54'd10,         54'd5,       54'd0,   54'd3,           1'b1, 54'd20, 54'd3,  tmr(11)};

    repeat (2) @(negedge clk);
    #1;
    chk("reset", {out_vld, done, out_x[15:0], npixels, timer[12:0]}, 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("idle_after_reset", {out_vld, done, 14'd0, npixels}, 48'd0);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      run_frame($sformatf("vec%0d", i), vecs[i]);
    end

    // Empty frames go straight to DONE without ever offering a coordinate.
    @(negedge clk);
    v = '{12'd0, 12'd5, 54'd1, 54'd1, 54'd1, 54'd1, 1'b0, 54'd0, 54'd0, 0};
    out_rdy = 1'b1;
    do_init(v);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("empty_h", {out_vld, done, npixels, timer}, {1'b0, 1'b1, 32'd0, 32'd0});
      @(negedge clk);
    end
    v.hres = 12'd3; v.vres = 12'd0;
    do_init(v);
    #1;
    chk("empty_v", {out_vld, done, npixels}, {1'b0, 1'b1, 32'd0});

    // Restart after 5 transfers: the new frame begins from its own x0.
    @(negedge clk);
    do_init(vecs[0]);
    out_rdy = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("pre_restart", {out_x, out_hcnt, out_vcnt}, {54'd1, 12'd1, 12'd1});
    v = '{12'd4, 12'd3, 54'd100, 54'd1, 54'd50, 54'd1, 1'b0, 54'd103, 54'd52, tmr(12)};
    run_frame("restart", v);

    // Reset mid-frame: everything clears at once and stays idle until init.
    @(negedge clk);
    do_init(vecs[0]);
    out_rdy = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid", {out_vld, done, npixels, out_x[29:0]}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk("rst_idle", {out_vld, done, npixels}, 34'd0);
    end
    @(negedge clk);
    run_frame("post_rst", vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
